// File: rtl/multi_channel_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : multi_channel_clock_divider
//  Description : N-channel programmable enable-tick divider. Each channel
//                emits a one-cycle tick every (DIV+1) clocks and can drive a
//                toggle output of period 2*(DIV+1). New divide values are
//                staged in a shadow register and take effect only at a period
//                boundary, or immediately while the channel is idle.
//                Optional macro DCD_PHASE_SYNC_EN adds i_SYNC, a global
//                restart that phase-aligns all channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_clock_divider #(
    parameter int P_CHANNELS    = 4,
    parameter int P_WIDTH       = 32,
    parameter int P_DEFAULT_DIV = 0
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic [P_CHANNELS-1:0]         i_ENABLE,
    input  logic [P_CHANNELS*P_WIDTH-1:0] i_DIV_VALUE,
    input  logic                          i_LOAD,
    input  logic [P_CHANNELS-1:0]         i_LOAD_MASK,
    input  logic [P_CHANNELS-1:0]         i_MODE,
`ifdef DCD_PHASE_SYNC_EN
    input  logic                          i_SYNC,
`endif
    output logic [P_CHANNELS-1:0]         o_TICK,
    output logic [P_CHANNELS-1:0]         o_CLK_OUT,
    output logic [P_CHANNELS-1:0]         o_PENDING
);

    localparam logic [P_WIDTH-1:0] c_DEFAULT_DIV = P_WIDTH'(P_DEFAULT_DIV);
    localparam logic [P_WIDTH-1:0] c_ONE         = P_WIDTH'(1);

    // Global restart request; tied low when the phase-sync option is absent.
    logic w_sync;
`ifdef DCD_PHASE_SYNC_EN
    assign w_sync = i_SYNC;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar gi = 0; gi < P_CHANNELS; gi++) begin : g_ch
        logic [P_WIDTH-1:0] r_count;
        logic [P_WIDTH-1:0] r_active;
        logic [P_WIDTH-1:0] r_shadow;
        logic               r_tick;
        logic               r_clk_out;
        logic               r_pending;

        logic [P_WIDTH-1:0] w_new_div;
        logic               w_en;
        logic               w_hit;
        logic               w_wrap;
        logic               w_load;
        logic               w_apply_slot;

        assign w_new_div    = i_DIV_VALUE[gi*P_WIDTH +: P_WIDTH];
        assign w_en         = i_ENABLE[gi];
        // Tick condition: final count of the current period.
        assign w_hit        = w_en & (r_count == r_active);
        // Period boundary; ">=" keeps the counter bounded by the active value.
        assign w_wrap       = w_en & (r_count >= r_active);
        assign w_load       = i_LOAD & i_LOAD_MASK[gi];
        // Safe moments to swap the divide value without distorting a period.
        assign w_apply_slot = w_wrap | ~w_en | w_sync;

        // Counter, tick, toggle output and shadow/active divide bookkeeping.
        always_ff @(posedge i_CLK) begin
            if (i_RST) begin
                r_count   <= '0;
                r_active  <= c_DEFAULT_DIV;
                r_shadow  <= c_DEFAULT_DIV;
                r_tick    <= 1'b0;
                r_clk_out <= 1'b0;
                r_pending <= 1'b0;
            end else begin
                if (!w_en || w_wrap || w_sync) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + c_ONE;
                end

                r_tick <= w_hit & ~w_sync;

                if (!w_en || !i_MODE[gi] || w_sync) begin
                    r_clk_out <= 1'b0;
                end else if (w_hit) begin
                    r_clk_out <= ~r_clk_out;
                end

                // A load landing on an apply slot bypasses the shadow wait;
                // the compare above still used the old active value.
                if (w_load && w_apply_slot) begin
                    r_shadow  <= w_new_div;
                    r_active  <= w_new_div;
                    r_pending <= 1'b0;
                end else if (w_load) begin
                    r_shadow  <= w_new_div;
                    r_pending <= 1'b1;
                end else if (r_pending && w_apply_slot) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end
            end
        end

        assign o_TICK[gi]    = r_tick;
        assign o_CLK_OUT[gi] = r_clk_out;
        assign o_PENDING[gi] = r_pending;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_channel_clock_divider
//  Description : Self-checking bench for multi_channel_clock_divider.
//                Expected {tick, clk_out, pending} per cycle are queued when
//                stimulus is applied and popped as the DUT advances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_clock_divider;

    localparam int P_CHANNELS = 4;
    localparam int P_WIDTH    = 8;

    logic                          i_CLK = 1'b0;
    logic                          i_RST;
    logic [P_CHANNELS-1:0]         i_ENABLE;
    logic [P_CHANNELS*P_WIDTH-1:0] i_DIV_VALUE;
    logic                          i_LOAD;
    logic [P_CHANNELS-1:0]         i_LOAD_MASK;
    logic [P_CHANNELS-1:0]         i_MODE;
`ifdef DCD_PHASE_SYNC_EN
    logic                          i_SYNC;
`endif
    logic [P_CHANNELS-1:0]         o_TICK;
    logic [P_CHANNELS-1:0]         o_CLK_OUT;
    logic [P_CHANNELS-1:0]         o_PENDING;

    int checks = 0;
    int errors = 0;
    logic [2:0] q_exp[$];   // {tick, clk_out, pending}

    multi_channel_clock_divider #(
        .P_CHANNELS   (P_CHANNELS),
        .P_WIDTH      (P_WIDTH),
        .P_DEFAULT_DIV(0)
    ) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_ENABLE   (i_ENABLE),
        .i_DIV_VALUE(i_DIV_VALUE),
        .i_LOAD     (i_LOAD),
        .i_LOAD_MASK(i_LOAD_MASK),
        .i_MODE     (i_MODE),
`ifdef DCD_PHASE_SYNC_EN
        .i_SYNC     (i_SYNC),
`endif
        .o_TICK     (o_TICK),
        .o_CLK_OUT  (o_CLK_OUT),
        .o_PENDING  (o_PENDING)
    );

    always #5 i_CLK = ~i_CLK;

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    // Load a divide value into one channel while it is idle (bypass path).
    task automatic load_disabled(input int ch, input logic [P_WIDTH-1:0] v);
        i_ENABLE[ch] = 1'b0;
        i_DIV_VALUE[ch*P_WIDTH +: P_WIDTH] = v;
        i_LOAD_MASK = '0;
        i_LOAD_MASK[ch] = 1'b1;
        i_LOAD = 1'b1;
        step();
        i_LOAD = 1'b0;
        i_LOAD_MASK = '0;
    endtask

    task automatic test_reset();
        i_RST = 1'b1;
        step();
        step();
        i_RST = 1'b0;
        checks++;
        if ({o_TICK, o_CLK_OUT, o_PENDING} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tick=%b clk=%b pend=%b, want all 0",
                     o_TICK, o_CLK_OUT, o_PENDING);
        end
    endtask

    // ch0, DIV=3 loaded while idle: ticks 4, 8, 12 cycles after enable.
    task automatic test_basic_div3();
        logic [2:0] e;
        load_disabled(0, 8'd3);
        checks++;
        if (o_PENDING[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_load_pending: got %b want 0", o_PENDING[0]);
        end
        for (int s = 1; s <= 13; s++) q_exp.push_back({(s % 4 == 0), 1'b0, 1'b0});
        i_ENABLE[0] = 1'b1;
        for (int s = 1; s <= 13; s++) begin
            step();
            e = q_exp.pop_front();
            checks++;
            if ({o_TICK[0], o_CLK_OUT[0], o_PENDING[0]} !== e) begin
                errors++;
                $display("FAIL div3 step %0d: got %b%b%b want %b", s,
                         o_TICK[0], o_CLK_OUT[0], o_PENDING[0], e);
            end
        end
        i_ENABLE[0] = 1'b0;
        step();
    endtask

    // ch1, DIV=0: tick always high, toggle flips every cycle.
    task automatic test_div0_toggle();
        logic [2:0] e;
        load_disabled(1, 8'd0);
        i_MODE[1] = 1'b1;
        for (int s = 1; s <= 8; s++) q_exp.push_back({1'b1, (s % 2 == 1), 1'b0});
        i_ENABLE[1] = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
            e = q_exp.pop_front();
            checks++;
            if ({o_TICK[1], o_CLK_OUT[1], o_PENDING[1]} !== e) begin
                errors++;
                $display("FAIL div0 step %0d: got %b%b%b want %b", s,
                         o_TICK[1], o_CLK_OUT[1], o_PENDING[1], e);
            end
        end
        i_ENABLE[1] = 1'b0;
        i_MODE[1]   = 1'b0;
        step();
    endtask

    // ch2, DIV=9 reprogrammed to 2 at count 4: period finishes, then every 3.
    task automatic test_midperiod_load();
        logic [2:0] e;
        load_disabled(2, 8'd9);
        for (int s = 1; s <= 19; s++)
            q_exp.push_back({(s == 10) || (s > 10 && (s - 10) % 3 == 0), 1'b0,
                             (s >= 5 && s <= 9)});
        i_ENABLE[2] = 1'b1;
        for (int s = 1; s <= 19; s++) begin
            if (s == 5) begin
                i_DIV_VALUE[2*P_WIDTH +: P_WIDTH] = 8'd2;
                i_LOAD_MASK = 4'b0100;
                i_LOAD = 1'b1;
            end
            step();
            i_LOAD = 1'b0;
            i_LOAD_MASK = '0;
            e = q_exp.pop_front();
            checks++;
            if ({o_TICK[2], o_CLK_OUT[2], o_PENDING[2]} !== e) begin
                errors++;
                $display("FAIL midload step %0d: got %b%b%b want %b", s,
                         o_TICK[2], o_CLK_OUT[2], o_PENDING[2], e);
            end
        end
        i_ENABLE[2] = 1'b0;
        step();
    endtask

    // ch3, DIV 5 -> 1 loaded exactly on the wrap: never pending.
    task automatic test_load_on_wrap();
        logic [2:0] e;
        load_disabled(3, 8'd5);
        for (int s = 1; s <= 12; s++)
            q_exp.push_back({(s == 6 || s == 8 || s == 10 || s == 12), 1'b0, 1'b0});
        i_ENABLE[3] = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            if (s == 6) begin
                i_DIV_VALUE[3*P_WIDTH +: P_WIDTH] = 8'd1;
                i_LOAD_MASK = 4'b1000;
                i_LOAD = 1'b1;
            end
            step();
            i_LOAD = 1'b0;
            i_LOAD_MASK = '0;
            e = q_exp.pop_front();
            checks++;
            if ({o_TICK[3], o_CLK_OUT[3], o_PENDING[3]} !== e) begin
                errors++;
                $display("FAIL wrapload step %0d: got %b%b%b want %b", s,
                         o_TICK[3], o_CLK_OUT[3], o_PENDING[3], e);
            end
        end
        i_ENABLE[3] = 1'b0;
        step();
    endtask

    // ch3, DIV=7, two loads while pending (4 then 1): only 1 is applied.
    task automatic test_overwrite();
        logic [2:0] e;
        load_disabled(3, 8'd7);
        for (int s = 1; s <= 12; s++)
            q_exp.push_back({(s == 8) || (s > 8 && (s - 8) % 2 == 0), 1'b0,
                             (s >= 2 && s <= 7)});
        i_ENABLE[3] = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            if (s == 2 || s == 3) begin
                i_DIV_VALUE[3*P_WIDTH +: P_WIDTH] = (s == 2) ? 8'd4 : 8'd1;
                i_LOAD_MASK = 4'b1000;
                i_LOAD = 1'b1;
            end
            step();
            i_LOAD = 1'b0;
            i_LOAD_MASK = '0;
            e = q_exp.pop_front();
            checks++;
            if ({o_TICK[3], o_CLK_OUT[3], o_PENDING[3]} !== e) begin
                errors++;
                $display("FAIL overwrite step %0d: got %b%b%b want %b", s,
                         o_TICK[3], o_CLK_OUT[3], o_PENDING[3], e);
            end
        end
        i_ENABLE[3] = 1'b0;
        step();
    endtask

    // ch0 (DIV=3, toggle on): disable mid-count, then restart from zero.
    task automatic test_enable_restart();
        logic [2:0] e;
        i_MODE[0]   = 1'b1;
        i_ENABLE[0] = 1'b1;
        for (int s = 1; s <= 6; s++) step();
        checks++;
        if (o_CLK_OUT[0] !== 1'b1) begin
            errors++;
            $display("FAIL run_clk_out: got %b want 1", o_CLK_OUT[0]);
        end
        i_ENABLE[0] = 1'b0;
        step();
        checks++;
        if ({o_TICK[0], o_CLK_OUT[0]} !== 2'b00) begin
            errors++;
            $display("FAIL disable_outputs: got tick=%b clk=%b want 0 0",
                     o_TICK[0], o_CLK_OUT[0]);
        end
        for (int s = 1; s <= 9; s++)
            q_exp.push_back({(s % 4 == 0), ((s / 4) % 2 == 1), 1'b0});
        i_ENABLE[0] = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            step();
            e = q_exp.pop_front();
            checks++;
            if ({o_TICK[0], o_CLK_OUT[0], o_PENDING[0]} !== e) begin
                errors++;
                $display("FAIL restart step %0d: got %b%b%b want %b", s,
                         o_TICK[0], o_CLK_OUT[0], o_PENDING[0], e);
            end
        end
        i_ENABLE[0] = 1'b0;
        i_MODE[0]   = 1'b0;
        step();
    endtask

    // ch2, DIV=255 (all ones): period 256 without counter wrap error.
    task automatic test_max_div();
        logic [2:0] e;
        load_disabled(2, 8'hFF);
        for (int s = 1; s <= 512; s++) q_exp.push_back({(s % 256 == 0), 1'b0, 1'b0});
        i_ENABLE[2] = 1'b1;
        for (int s = 1; s <= 512; s++) begin
            step();
            e = q_exp.pop_front();
            if (e[2] || s % 64 == 0 || o_TICK[2] !== 1'b0) begin
                checks++;
                if ({o_TICK[2], o_CLK_OUT[2], o_PENDING[2]} !== e) begin
                    errors++;
                    $display("FAIL maxdiv step %0d: got %b%b%b want %b", s,
                             o_TICK[2], o_CLK_OUT[2], o_PENDING[2], e);
                end
            end
        end
        i_ENABLE[2] = 1'b0;
        step();
    endtask

    // Reset mid-run, coincident with a load: everything back to defaults.
    task automatic test_reset_midrun();
        i_ENABLE = '1;
        i_MODE   = '1;
        for (int s = 1; s <= 5; s++) step();
        i_DIV_VALUE = {P_CHANNELS{8'd7}};
        i_LOAD_MASK = '1;
        i_LOAD      = 1'b1;
        i_RST       = 1'b1;
        step();
        i_RST  = 1'b0;
        i_LOAD = 1'b0;
        checks++;
        if ({o_TICK, o_CLK_OUT, o_PENDING} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got tick=%b clk=%b pend=%b want all 0",
                     o_TICK, o_CLK_OUT, o_PENDING);
        end
        // Default divide of 0 means every enabled channel ticks at once.
        step();
        checks++;
        if (o_TICK !== 4'hF || o_CLK_OUT !== 4'hF) begin
            errors++;
            $display("FAIL default_div_after_reset: got tick=%b clk=%b want 1111 1111",
                     o_TICK, o_CLK_OUT);
        end
        i_ENABLE = '0;
        i_MODE   = '0;
        step();
    endtask

`ifdef DCD_PHASE_SYNC_EN
    // ch0/ch1 at DIV=4 with offset phases; i_SYNC aligns them.
    task automatic test_phase_sync();
        logic [2:0] e;
        load_disabled(0, 8'd4);
        load_disabled(1, 8'd4);
        i_ENABLE[0] = 1'b1;
        step();
        step();
        i_ENABLE[1] = 1'b1;
        for (int s = 1; s <= 3; s++) step();
        i_SYNC = 1'b1;
        step();
        i_SYNC = 1'b0;
        checks++;
        if (o_TICK[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL sync_tick: got %b want 00", o_TICK[1:0]);
        end
        for (int s = 1; s <= 10; s++) q_exp.push_back({(s % 5 == 0), 1'b0, 1'b0});
        for (int s = 1; s <= 10; s++) begin
            step();
            e = q_exp.pop_front();
            checks++;
            if (o_TICK[0] !== e[2] || o_TICK[1] !== e[2]) begin
                errors++;
                $display("FAIL sync_align step %0d: got %b want %b%b", s,
                         o_TICK[1:0], e[2], e[2]);
            end
        end
        i_ENABLE = '0;
        step();
    endtask
`endif

    initial begin
        i_RST       = 1'b1;
        i_ENABLE    = '0;
        i_DIV_VALUE = '0;
        i_LOAD      = 1'b0;
        i_LOAD_MASK = '0;
        i_MODE      = '0;
`ifdef DCD_PHASE_SYNC_EN
        i_SYNC      = 1'b0;
`endif
        test_reset();
        test_basic_div3();
        test_div0_toggle();
        test_midperiod_load();
        test_load_on_wrap();
        test_overwrite();
        test_enable_restart();
        test_max_div();
        test_reset_midrun();
`ifdef DCD_PHASE_SYNC_EN
        test_phase_sync();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
